// File: rtl/video_timing_gen.sv
// Parametrised raster timing generator: pixel/line counters, syncs, display enable,
// line/frame strobes, a frame counter and a raster-line / vblank interrupt pair.
// Latency: every output is registered and is decoded from the counter values that the
// same clock edge loads, so all outputs describe the pixel currently shown in h_count/v_count.
// Backpressure: none. pixel_en gates raster advance. With pixel_en low the raster state
// holds and the strobes stay low.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   pixel_en              advance the raster by one pixel this clock
//   h_count, v_count      current pixel column / line
//   visible, h_sync, v_sync, line_start, frame_start, frame_count   raster decode
//   irq_line_write/in, irq_enable_write/in, irq_ack                 CPU register access
//   irq_status, irq       pending interrupt bits and the gated interrupt line
module video_timing_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int H_SYNC_POL  = 0,
  parameter int V_SYNC_POL  = 0,
  parameter int COUNT_WIDTH = 10,
  parameter int FRAME_WIDTH = 10
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pixel_en,
  output logic [COUNT_WIDTH-1:0] h_count,
  output logic [COUNT_WIDTH-1:0] v_count,
  output logic                   visible,
  output logic                   h_sync,
  output logic                   v_sync,
  output logic                   line_start,
  output logic                   frame_start,
  output logic [FRAME_WIDTH-1:0] frame_count,
  input  logic                   irq_line_write,
  input  logic [COUNT_WIDTH-1:0] irq_line_in,
  input  logic                   irq_enable_write,
  input  logic [1:0]             irq_enable_in,
  input  logic [1:0]             irq_ack,
  output logic [1:0]             irq_status,
  output logic                   irq
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [COUNT_WIDTH-1:0] H_LAST = COUNT_WIDTH'(H_TOTAL - 1);
  localparam logic [COUNT_WIDTH-1:0] V_LAST = COUNT_WIDTH'(V_TOTAL - 1);

  // Region boundaries carry one spare bit so a sync that ends exactly at the
  // counter's full range still compares correctly.
  localparam logic [COUNT_WIDTH:0] H_VIS_X   = (COUNT_WIDTH+1)'(H_VISIBLE);
  localparam logic [COUNT_WIDTH:0] H_SS_X    = (COUNT_WIDTH+1)'(H_VISIBLE + H_FRONT);
  localparam logic [COUNT_WIDTH:0] H_SE_X    = (COUNT_WIDTH+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [COUNT_WIDTH:0] V_VIS_X   = (COUNT_WIDTH+1)'(V_VISIBLE);
  localparam logic [COUNT_WIDTH:0] V_SS_X    = (COUNT_WIDTH+1)'(V_VISIBLE + V_FRONT);
  localparam logic [COUNT_WIDTH:0] V_SE_X    = (COUNT_WIDTH+1)'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic H_ACT = (H_SYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic V_ACT = (V_SYNC_POL != 0) ? 1'b1 : 1'b0;

  logic [COUNT_WIDTH-1:0] h_q, h_d, v_q, v_d;
  logic [FRAME_WIDTH-1:0] frame_q, frame_d;
  logic                   visible_q, visible_d;
  logic                   h_sync_q, h_sync_d, v_sync_q, v_sync_d;
  logic                   line_start_q, line_start_d;
  logic                   frame_start_q, frame_start_d;
  logic [COUNT_WIDTH-1:0] irq_line_q, irq_line_d;
  logic [1:0]             irq_enable_q, irq_enable_d;
  logic [1:0]             irq_status_q, irq_status_d;
  logic                   irq_q, irq_d;

  logic                   h_wrap, v_wrap;
  logic [1:0]             irq_set;
  logic [COUNT_WIDTH:0]   h_ext, v_ext;

  always_comb begin
    h_wrap        = (h_q == H_LAST);
    v_wrap        = (v_q == V_LAST);
    h_d           = h_q;
    v_d           = v_q;
    frame_d       = frame_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    irq_set       = 2'b00;

    if (pixel_en) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) begin
        v_d          = v_wrap ? '0 : v_q + 1'b1;
        line_start_d = 1'b1;
        if (v_wrap) begin
          frame_d       = frame_q + 1'b1;
          frame_start_d = 1'b1;
        end
        // Compare against the register value before any write on this edge.
        irq_set[0] = (v_d == irq_line_q);
        irq_set[1] = ({1'b0, v_d} == V_VIS_X);
      end
    end

    // Decode from the next counter values so the registered decode lines up
    // with the registered counters.
    h_ext     = {1'b0, h_d};
    v_ext     = {1'b0, v_d};
    visible_d = (h_ext < H_VIS_X) && (v_ext < V_VIS_X);
    h_sync_d  = ((h_ext >= H_SS_X) && (h_ext < H_SE_X)) ? H_ACT : ~H_ACT;
    v_sync_d  = ((v_ext >= V_SS_X) && (v_ext < V_SE_X)) ? V_ACT : ~V_ACT;

    // A set on the same edge as an ack wins.
    irq_status_d = (irq_status_q & ~irq_ack) | irq_set;
    irq_line_d   = irq_line_write   ? irq_line_in   : irq_line_q;
    irq_enable_d = irq_enable_write ? irq_enable_in : irq_enable_q;
    irq_d        = |(irq_status_d & irq_enable_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      h_q           <= H_LAST;
      v_q           <= V_LAST;
      frame_q       <= '1;
      visible_q     <= 1'b0;
      h_sync_q      <= ~H_ACT;
      v_sync_q      <= ~V_ACT;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      irq_line_q    <= '0;
      irq_enable_q  <= 2'b00;
      irq_status_q  <= 2'b00;
      irq_q         <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      frame_q       <= frame_d;
      visible_q     <= visible_d;
      h_sync_q      <= h_sync_d;
      v_sync_q      <= v_sync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      irq_line_q    <= irq_line_d;
      irq_enable_q  <= irq_enable_d;
      irq_status_q  <= irq_status_d;
      irq_q         <= irq_d;
    end
  end

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign frame_count = frame_q;
  assign visible     = visible_q;
  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign irq_status  = irq_status_q;
  assign irq         = irq_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three instances (default 640x480 mode, a tiny 8x6 mode,
// and a 17x11 mode with active-high syncs and a 3-bit frame counter) are driven together
// and compared every cycle against a position-from-step-count model.
module tb_video_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Mode table, index 0 = default, 1 = tiny, 2 = mid with positive syncs.
  localparam int HV[3] = '{640, 4, 10};
  localparam int HF[3] = '{16, 1, 2};
  localparam int HS[3] = '{96, 2, 3};
  localparam int HB[3] = '{48, 1, 2};
  localparam int VV[3] = '{480, 3, 6};
  localparam int VF[3] = '{10, 1, 2};
  localparam int VS[3] = '{2, 1, 2};
  localparam int VB[3] = '{33, 1, 1};
  localparam int HP[3] = '{0, 0, 1};
  localparam int VP[3] = '{0, 0, 1};
  localparam int FW[3] = '{10, 4, 3};

  logic       rst    [3];
  logic       en     [3];
  logic       ilw    [3];
  logic [9:0] il_in  [3];
  logic       iew    [3];
  logic [1:0] ie_in  [3];
  logic [1:0] ack    [3];

  logic [9:0] a_h, a_v, a_fc;
  logic [3:0] b_h, b_v, b_fc;
  logic [4:0] c_h, c_v;
  logic [2:0] c_fc;
  logic       a_vis, a_hs, a_vs, a_ls, a_fs, a_irq;
  logic       b_vis, b_hs, b_vs, b_ls, b_fs, b_irq;
  logic       c_vis, c_hs, c_vs, c_ls, c_fs, c_irq;
  logic [1:0] a_st, b_st, c_st;

  video_timing_gen dut_a (
    .clock(clk), .reset(rst[0]), .pixel_en(en[0]),
    .h_count(a_h), .v_count(a_v), .visible(a_vis), .h_sync(a_hs), .v_sync(a_vs),
    .line_start(a_ls), .frame_start(a_fs), .frame_count(a_fc),
    .irq_line_write(ilw[0]), .irq_line_in(il_in[0]),
    .irq_enable_write(iew[0]), .irq_enable_in(ie_in[0]), .irq_ack(ack[0]),
    .irq_status(a_st), .irq(a_irq));

  video_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(0), .V_SYNC_POL(0), .COUNT_WIDTH(4), .FRAME_WIDTH(4)
  ) dut_b (
    .clock(clk), .reset(rst[1]), .pixel_en(en[1]),
    .h_count(b_h), .v_count(b_v), .visible(b_vis), .h_sync(b_hs), .v_sync(b_vs),
    .line_start(b_ls), .frame_start(b_fs), .frame_count(b_fc),
    .irq_line_write(ilw[1]), .irq_line_in(il_in[1][3:0]),
    .irq_enable_write(iew[1]), .irq_enable_in(ie_in[1]), .irq_ack(ack[1]),
    .irq_status(b_st), .irq(b_irq));

  video_timing_gen #(
    .H_VISIBLE(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1), .V_SYNC_POL(1), .COUNT_WIDTH(5), .FRAME_WIDTH(3)
  ) dut_c (
    .clock(clk), .reset(rst[2]), .pixel_en(en[2]),
    .h_count(c_h), .v_count(c_v), .visible(c_vis), .h_sync(c_hs), .v_sync(c_vs),
    .line_start(c_ls), .frame_start(c_fs), .frame_count(c_fc),
    .irq_line_write(ilw[2]), .irq_line_in(il_in[2][4:0]),
    .irq_enable_write(iew[2]), .irq_enable_in(ie_in[2]), .irq_ack(ack[2]),
    .irq_status(c_st), .irq(c_irq));

  // Model state: number of raster steps since reset fully determines the position.
  longint     steps [3];
  int         m_il  [3];
  logic [1:0] m_en  [3];
  logic [1:0] m_st  [3];
  logic       m_ls  [3];
  logic       m_fs  [3];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string name, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d: got %0d expected %0d", name, k, cyc, act, exp);
    end
  endtask

  // Position, frame number and region flags after s steps.
  task automatic exp_pos(input int k, input longint s, output int h, output int v,
                         output int fc, output int vis, output int hs_on, output int vs_on);
    int     ht, vt;
    longint p;
    ht = HV[k] + HF[k] + HS[k] + HB[k];
    vt = VV[k] + VF[k] + VS[k] + VB[k];
    if (s == 0) begin
      h = ht - 1; v = vt - 1; fc = (1 << FW[k]) - 1; vis = 0; hs_on = 0; vs_on = 0;
    end else begin
      p     = s - 1;
      h     = int'(p % ht);
      v     = int'((p / ht) % vt);
      fc    = int'((p / (ht * vt)) % (1 << FW[k]));
      vis   = (h < HV[k] && v < VV[k]) ? 1 : 0;
      hs_on = (h >= HV[k] + HF[k] && h < HV[k] + HF[k] + HS[k]) ? 1 : 0;
      vs_on = (v >= VV[k] + VF[k] && v < VV[k] + VF[k] + VS[k]) ? 1 : 0;
    end
  endtask

  task automatic model_step(input int k);
    int h, v, fc, vis, hs_on, vs_on;
    logic [1:0] set;
    if (rst[k]) begin
      steps[k] = 0; m_il[k] = 0; m_en[k] = 2'b00; m_st[k] = 2'b00;
      m_ls[k] = 1'b0; m_fs[k] = 1'b0;
    end else begin
      set = 2'b00; m_ls[k] = 1'b0; m_fs[k] = 1'b0;
      if (en[k]) begin
        steps[k]++;
        exp_pos(k, steps[k], h, v, fc, vis, hs_on, vs_on);
        if (h == 0) begin
          m_ls[k] = 1'b1;
          m_fs[k] = (v == 0);
          set[0]  = (v == m_il[k]);
          set[1]  = (v == VV[k]);
        end
      end
      m_st[k] = (m_st[k] & ~ack[k]) | set;
      if (ilw[k]) m_il[k] = int'(il_in[k]);
      if (iew[k]) m_en[k] = ie_in[k];
    end
  endtask

  task automatic compare(input int k);
    int h, v, fc, vis, hs_on, vs_on;
    int oh, ov, ofc, ovis, ohs, ovs, ols, ofs, ost, oirq;
    case (k)
      0: begin oh = int'(a_h); ov = int'(a_v); ofc = int'(a_fc); ovis = int'(a_vis);
               ohs = int'(a_hs); ovs = int'(a_vs); ols = int'(a_ls); ofs = int'(a_fs);
               ost = int'(a_st); oirq = int'(a_irq); end
      1: begin oh = int'(b_h); ov = int'(b_v); ofc = int'(b_fc); ovis = int'(b_vis);
               ohs = int'(b_hs); ovs = int'(b_vs); ols = int'(b_ls); ofs = int'(b_fs);
               ost = int'(b_st); oirq = int'(b_irq); end
      default: begin oh = int'(c_h); ov = int'(c_v); ofc = int'(c_fc); ovis = int'(c_vis);
               ohs = int'(c_hs); ovs = int'(c_vs); ols = int'(c_ls); ofs = int'(c_fs);
               ost = int'(c_st); oirq = int'(c_irq); end
    endcase
    exp_pos(k, steps[k], h, v, fc, vis, hs_on, vs_on);
    check("h_count", k, oh, h);
    check("v_count", k, ov, v);
    check("frame_count", k, ofc, fc);
    check("visible", k, ovis, vis);
    check("h_sync", k, ohs, (hs_on != 0) ? HP[k] : 1 - HP[k]);
    check("v_sync", k, ovs, (vs_on != 0) ? VP[k] : 1 - VP[k]);
    check("line_start", k, ols, int'(m_ls[k]));
    check("frame_start", k, ofs, int'(m_fs[k]));
    check("irq_status", k, ost, int'(m_st[k]));
    check("irq", k, oirq, int'(|(m_st[k] & m_en[k])));
  endtask

  task automatic tick();
    for (int k = 0; k < 3; k++) model_step(k);
    @(negedge clk);
    cyc++;
    for (int k = 0; k < 3; k++) compare(k);
  endtask

  task automatic rand_inputs(input int k);
    en[k]    = (k == 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
    rst[k]   = ($urandom_range(0, 699) == 0);
    ilw[k]   = ($urandom_range(0, 15) == 0);
    il_in[k] = 10'($urandom_range(0, 15));
    iew[k]   = ($urandom_range(0, 15) == 0);
    ie_in[k] = 2'($urandom_range(0, 3));
    ack[k]   = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
  endtask

  int last_ls = 0;
  int ls_gap_found = 0;

  initial begin
    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b1; en[k] = 1'b1; ilw[k] = 1'b0; il_in[k] = '0;
      iew[k] = 1'b0; ie_in[k] = 2'b00; ack[k] = 2'b00;
      steps[k] = 0; m_il[k] = 0; m_en[k] = 2'b00; m_st[k] = 2'b00;
      m_ls[k] = 1'b0; m_fs[k] = 1'b0;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick();

    check("lit_reset_h", 0, int'(a_h), 799);
    check("lit_reset_v", 0, int'(a_v), 524);
    check("lit_reset_fc", 0, int'(a_fc), 1023);
    check("lit_reset_hsync", 0, int'(a_hs), 1);
    check("lit_reset_vis", 0, int'(a_vis), 0);

    for (int c = 1; c <= 8500; c++) begin
      for (int k = 0; k < 3; k++) begin
        rst[k] = 1'b0; ilw[k] = 1'b0; iew[k] = 1'b0; ack[k] = 2'b00;
      end
      // Default mode: straight run into line 5, then half-rate, then random.
      if (c <= 4100) begin
        en[0] = 1'b1;
        if (c == 1) begin ilw[0] = 1'b1; il_in[0] = 10'd5; iew[0] = 1'b1; ie_in[0] = 2'b01; end
        if (c == 2) ack[0] = 2'b01;
      end else if (c <= 7500) begin
        en[0] = ((c % 2) == 1);
      end else begin
        rand_inputs(0);
      end
      // Tiny mode: scripted vblank and set-beats-ack sequence, then random.
      if (c <= 60) begin
        en[1] = 1'b1;
        if (c == 2) ack[1] = 2'b01;
        if (c == 26) begin ilw[1] = 1'b1; il_in[1] = 10'd1; iew[1] = 1'b1; ie_in[1] = 2'b01; end
        if (c == 50) ack[1] = 2'b11;
        if (c == 57) ack[1] = 2'b01;
      end else begin
        rand_inputs(1);
      end
      rand_inputs(2);
      if (c == 8000) begin
        rst[0] = 1'b1; en[0] = 1'b0; rst[1] = 1'b1; rst[2] = 1'b1;
      end

      tick();

      case (c)
        1: begin
          check("lit_first_h", 0, int'(a_h), 0);
          check("lit_first_v", 0, int'(a_v), 0);
          check("lit_first_vis", 0, int'(a_vis), 1);
          check("lit_first_ls", 0, int'(a_ls), 1);
          check("lit_first_fs", 0, int'(a_fs), 1);
          check("lit_first_fc", 0, int'(a_fc), 0);
        end
        24:  check("lit_b_status_pre", 1, int'(b_st), 0);
        25: begin
          check("lit_b_vblank_v", 1, int'(b_v), 3);
          check("lit_b_vblank_h", 1, int'(b_h), 0);
          check("lit_b_vblank_st", 1, int'(b_st), 2);
          check("lit_b_vblank_irq", 1, int'(b_irq), 0);
        end
        51:  check("lit_b_acked", 1, int'(b_st), 0);
        57: begin
          check("lit_b_set_wins", 1, int'(b_st), 1);
          check("lit_b_irq", 1, int'(b_irq), 1);
        end
        640: check("lit_vis_639", 0, int'(a_vis), 1);
        641: check("lit_vis_640", 0, int'(a_vis), 0);
        656: check("lit_hs_655", 0, int'(a_hs), 1);
        657: check("lit_hs_656", 0, int'(a_hs), 0);
        752: check("lit_hs_751", 0, int'(a_hs), 0);
        753: check("lit_hs_752", 0, int'(a_hs), 1);
        800: check("lit_h_799", 0, int'(a_h), 799);
        801: begin
          check("lit_wrap_h", 0, int'(a_h), 0);
          check("lit_wrap_v", 0, int'(a_v), 1);
          check("lit_wrap_ls", 0, int'(a_ls), 1);
        end
        4000: check("lit_irq_before", 0, int'(a_irq), 0);
        4001: begin
          check("lit_irq_v", 0, int'(a_v), 5);
          check("lit_irq_rise", 0, int'(a_irq), 1);
          check("lit_irq_st", 0, int'(a_st), 1);
        end
        4002: check("lit_irq_hold", 0, int'(a_irq), 1);
        default: ;
      endcase

      if (c > 4100 && c <= 7500 && a_ls) begin
        if (last_ls > 0 && ls_gap_found == 0) begin
          check("lit_half_rate_line", 0, c - last_ls, 1600);
          ls_gap_found = 1;
        end
        last_ls = c;
      end
    end

    check("half_rate_line_seen", 0, ls_gap_found, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
